// File: rtl/power_iteration_ctrl.sv
// Power-iteration sequencer: serial A*v MAC, power-of-two renormalisation,
// convergence check, then a fixed-latency eigenvalue capture.
module power_iteration_ctrl #(
    parameter int SIZE_N   = 8,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 32,
    parameter int TOL      = 16,
    parameter int EIG_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] matrix_in [SIZE_N][SIZE_N],
    input  logic signed [31:0] eigenvalue_in,
    output logic signed [31:0] vec_out [SIZE_N],
    output logic signed [31:0] eigenvalue_out,
    output logic [7:0]         iterations,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               zero_err
);
    localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam int CW = $clog2(EIG_LAT + 1);
    localparam logic [IW-1:0] LAST = IW'(SIZE_N - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MAC, S_NSCAN, S_NAPPLY, S_CHECK, S_EIG, S_DONE
    } state_t;

    state_t state, nstate;

    logic signed [31:0] a_q   [SIZE_N][SIZE_N];
    logic signed [31:0] v_old [SIZE_N];
    logic signed [31:0] v_new [SIZE_N];
    logic signed [63:0] w_q   [SIZE_N];
    logic signed [63:0] acc, a_x, v_x, prod, w_sel, dif;
    logic [63:0]        m_q, d_q, w_abs, d_abs, m_nxt, d_nxt;
    logic [IW-1:0]      ii, jj;
    logic [CW-1:0]      ecnt;
    logic [6:0]         msb, sh;
    logic               left, row_end, vec_end, eig_end;

    // Datapath helpers: current product, running maxima, normalised vector
    always_comb begin
        a_x     = 64'(a_q[ii][jj]);
        v_x     = 64'(vec_out[jj]);
        prod    = a_x * v_x;
        w_sel   = w_q[ii];
        w_abs   = w_sel[63] ? 64'(-w_sel) : 64'(w_sel);
        m_nxt   = (w_abs > m_q) ? w_abs : m_q;
        dif     = 64'(vec_out[ii]) - 64'(v_old[ii]);
        d_abs   = dif[63] ? 64'(-dif) : 64'(dif);
        d_nxt   = (d_abs > d_q) ? d_abs : d_q;
        row_end = (jj == LAST);
        vec_end = (ii == LAST);
        eig_end = (ecnt == CW'(EIG_LAT - 1));
        msb     = '0;
        for (int b = 0; b < 64; b++) begin
            if (m_q[b]) msb = 7'(b);
        end
        left = (msb <= 7'(FRAC));
        sh   = left ? (7'(FRAC) - msb) : (msb - 7'(FRAC));
        for (int i = 0; i < SIZE_N; i++) begin
            if (left) v_new[i] = 32'(w_q[i] <<< sh);
            else      v_new[i] = 32'(w_q[i] >>> sh);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nstate;
    end

    // Next-state and status decode
    always_comb begin
        nstate = state;
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        unique case (state)
            S_IDLE:   if (start) nstate = S_MAC;
            S_MAC:    if (row_end && vec_end) nstate = S_NSCAN;
            S_NSCAN:  if (vec_end) nstate = (m_nxt == '0) ? S_DONE : S_NAPPLY;
            S_NAPPLY: nstate = S_CHECK;
            S_CHECK: begin
                if (vec_end) begin
                    if (d_nxt <= 64'(TOL))                nstate = S_EIG;
                    else if (iterations == 8'(MAX_ITER)) nstate = S_EIG;
                    else                                  nstate = S_MAC;
                end
            end
            S_EIG:    if (eig_end) nstate = S_DONE;
            S_DONE:   nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    // Datapath registers and result outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SIZE_N; i++) vec_out[i] <= '0;
            eigenvalue_out <= '0;
            iterations     <= '0;
            converged      <= 1'b0;
            zero_err       <= 1'b0;
            acc            <= '0;
            m_q            <= '0;
            d_q            <= '0;
            ii             <= '0;
            jj             <= '0;
            ecnt           <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q <= matrix_in;
                        for (int i = 0; i < SIZE_N; i++)
                            vec_out[i] <= 32'(1) <<< FRAC;
                        iterations <= '0;
                        converged  <= 1'b0;
                        zero_err   <= 1'b0;
                        acc        <= '0;
                        ii         <= '0;
                        jj         <= '0;
                    end
                end
                S_MAC: begin
                    if (row_end) begin
                        w_q[ii] <= (acc + prod) >>> FRAC;
                        acc     <= '0;
                        jj      <= '0;
                        ii      <= vec_end ? '0 : ii + 1'b1;
                        m_q     <= '0;
                    end else begin
                        acc <= acc + prod;
                        jj  <= jj + 1'b1;
                    end
                end
                S_NSCAN: begin
                    m_q <= m_nxt;
                    ii  <= vec_end ? '0 : ii + 1'b1;
                    if (vec_end && m_nxt == '0) zero_err <= 1'b1;
                end
                S_NAPPLY: begin
                    v_old      <= vec_out;
                    vec_out    <= v_new;
                    iterations <= iterations + 8'd1;
                    d_q        <= '0;
                    ii         <= '0;
                end
                S_CHECK: begin
                    d_q  <= d_nxt;
                    ii   <= vec_end ? '0 : ii + 1'b1;
                    ecnt <= '0;
                    if (vec_end && d_nxt <= 64'(TOL)) converged <= 1'b1;
                end
                S_EIG: begin
                    ecnt <= ecnt + 1'b1;
                    if (eig_end) eigenvalue_out <= eigenvalue_in;
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_power_iteration_ctrl.sv
// Randomised bench for power_iteration_ctrl against an arithmetic
// reference model of the power iteration and its cycle budget.
module tb_power_iteration_ctrl;
    localparam int FRAC = 16;
    localparam int TOL  = 16;
    localparam int LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               start2 = 1'b0;
    logic               start8 = 1'b0;
    logic signed [31:0] mat2 [2][2];
    logic signed [31:0] mat8 [8][8];
    logic signed [31:0] eig2, eig8;
    logic signed [31:0] va [2];
    logic signed [31:0] vb [2];
    logic signed [31:0] v8 [8];
    logic signed [31:0] ea, eb, e8;
    logic [7:0]         ia, ib, i8;
    logic ba, da, ca, za, bb, db, cb, zb, b8, d8, c8, z8;

    power_iteration_ctrl #(
        .SIZE_N(2), .FRAC(FRAC), .MAX_ITER(32), .TOL(TOL), .EIG_LAT(LAT)
    ) u2a (
        .clk(clk), .rst(rst), .start(start2), .matrix_in(mat2),
        .eigenvalue_in(eig2), .vec_out(va), .eigenvalue_out(ea),
        .iterations(ia), .busy(ba), .done(da), .converged(ca), .zero_err(za)
    );

    power_iteration_ctrl #(
        .SIZE_N(2), .FRAC(FRAC), .MAX_ITER(5), .TOL(TOL), .EIG_LAT(LAT)
    ) u2b (
        .clk(clk), .rst(rst), .start(start2), .matrix_in(mat2),
        .eigenvalue_in(eig2), .vec_out(vb), .eigenvalue_out(eb),
        .iterations(ib), .busy(bb), .done(db), .converged(cb), .zero_err(zb)
    );

    power_iteration_ctrl #(
        .SIZE_N(8), .FRAC(FRAC), .MAX_ITER(32), .TOL(TOL), .EIG_LAT(LAT)
    ) u8 (
        .clk(clk), .rst(rst), .start(start8), .matrix_in(mat8),
        .eigenvalue_in(eig8), .vec_out(v8), .eigenvalue_out(e8),
        .iterations(i8), .busy(b8), .done(d8), .converged(c8), .zero_err(z8)
    );

    int     errs = 0;
    int     checks = 0;
    longint exp_ea = 0, exp_eb = 0, exp_e8 = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: iterate w = (A v) / 2^FRAC, rescale so max |v| lands in
    // [2^FRAC, 2^(FRAC+1)), stop on small change, iteration cap or zero w.
    function automatic void model(input longint a [8][8], input int n,
                                  input int mx, output int it, output bit cv,
                                  output bit zr, output longint v [8],
                                  output int cyc);
        longint w [8];
        longint vn [8];
        longint s, m, d, x;
        int     p;
        bit     fin;
        int     l;
        l = n * n + 2 * n + 1;
        for (int i = 0; i < 8; i++) v[i] = 64'sd1 << FRAC;
        it = 0; cv = 0; zr = 0; fin = 0; cyc = 0;
        while (!fin) begin
            m = 0;
            for (int i = 0; i < n; i++) begin
                s = 0;
                for (int j = 0; j < n; j++) s += a[i][j] * v[j];
                w[i] = s >>> FRAC;
                x = (w[i] < 0) ? -w[i] : w[i];
                if (x > m) m = x;
            end
            if (m == 0) begin
                zr = 1; fin = 1;
                cyc = it * l + n * n + n;
            end else begin
                p = 0;
                while ((m >> (p + 1)) != 0) p++;
                d = 0;
                for (int i = 0; i < n; i++) begin
                    vn[i] = (p <= FRAC) ? (w[i] <<< (FRAC - p))
                                        : (w[i] >>> (p - FRAC));
                    vn[i] = longint'(int'(vn[i]));
                    x = vn[i] - v[i];
                    if (x < 0) x = -x;
                    if (x > d) d = x;
                end
                for (int i = 0; i < n; i++) v[i] = vn[i];
                it++;
                if (d <= TOL) begin cv = 1; fin = 1; end
                else if (it >= mx) fin = 1;
                if (fin) cyc = it * l + LAT;
            end
        end
    endfunction

    task automatic chk_run(input string t, input int n, input int dn,
                           input int at, input int bs, input longint g_it,
                           input longint g_cv, input longint g_zr,
                           input longint g_ev, input longint g_v [8],
                           input int e_it, input bit e_cv, input bit e_zr,
                           input longint e_ev, input longint e_v [8],
                           input int e_cyc);
        chk({t, ".done_cnt"}, dn, 1);
        chk({t, ".done_at"}, at, e_cyc);
        chk({t, ".busy_cyc"}, bs, e_cyc + 1);
        chk({t, ".iters"}, g_it, e_it);
        chk({t, ".conv"}, g_cv, e_cv);
        chk({t, ".zero"}, g_zr, e_zr);
        chk({t, ".eig"}, g_ev, e_ev);
        for (int i = 0; i < n; i++) chk({t, ".vec"}, g_v[i], e_v[i]);
    endtask

    task automatic chk_reset2(input string t);
        chk({t, ".busy"}, ba, 0);
        chk({t, ".done"}, da, 0);
        chk({t, ".iters"}, ia, 0);
        chk({t, ".conv"}, ca, 0);
        chk({t, ".zero"}, za, 0);
        chk({t, ".eig"}, ea, 0);
        chk({t, ".vec0"}, va[0], 0);
        chk({t, ".vec1"}, va[1], 0);
        chk({t, ".busy_b"}, bb, 0);
        chk({t, ".iters_b"}, ib, 0);
    endtask

    // mode 0: plain run, 1: re-pulse start and scramble matrix mid-run,
    // 2: assert reset mid-MAC
    task automatic run2(input string t, input longint a [8][8],
                        input int ev, input int mode);
        int     ita, itb, cya, cyb, lim;
        bit     cva, cvb, zra, zrb;
        longint vxa [8];
        longint vxb [8];
        longint ga [8];
        longint gb [8];
        int     dna, dnb, ata, atb, bsa, bsb;
        model(a, 2, 32, ita, cva, zra, vxa, cya);
        model(a, 2, 5, itb, cvb, zrb, vxb, cyb);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) mat2[i][j] = 32'(a[i][j]);
        eig2 = ev;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        lim = ((cya > cyb) ? cya : cyb) + 4;
        dna = 0; dnb = 0; ata = -1; atb = -1; bsa = 0; bsb = 0;
        for (int c = 0; c <= lim; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (mode == 2 && c == 4) begin
                chk_reset2({t, ".rst"});
                rst = 1'b1;
            end
            if (da) begin dna++; ata = c; end
            if (db) begin dnb++; atb = c; end
            if (ba) bsa++;
            if (bb) bsb++;
            if (mode == 1 && c == 2) begin
                start2 = 1'b1;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) mat2[i][j] = $urandom;
            end
            if (mode == 1 && c == 3) start2 = 1'b0;
            if (mode == 2 && c == 3) rst = 1'b0;
        end
        if (mode == 2) begin
            chk({t, ".no_done_a"}, dna, 0);
            chk({t, ".no_done_b"}, dnb, 0);
            exp_ea = 0; exp_eb = 0; exp_e8 = 0;
        end else begin
            if (!zra) exp_ea = ev;
            if (!zrb) exp_eb = ev;
            for (int i = 0; i < 8; i++) begin
                ga[i] = (i < 2) ? longint'(va[i]) : 0;
                gb[i] = (i < 2) ? longint'(vb[i]) : 0;
            end
            chk_run({t, ".a"}, 2, dna, ata, bsa, ia, ca, za, ea, ga,
                    ita, cva, zra, exp_ea, vxa, cya);
            chk_run({t, ".b"}, 2, dnb, atb, bsb, ib, cb, zb, eb, gb,
                    itb, cvb, zrb, exp_eb, vxb, cyb);
        end
    endtask

    task automatic run8(input string t, input longint a [8][8], input int ev);
        int     it, cy, lim, dn, at, bs;
        bit     cv, zr;
        longint vx [8];
        longint g [8];
        model(a, 8, 32, it, cv, zr, vx, cy);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mat8[i][j] = 32'(a[i][j]);
        eig8 = ev;
        @(negedge clk);
        start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        lim = cy + 4;
        dn = 0; at = -1; bs = 0;
        for (int c = 0; c <= lim; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (d8) begin dn++; at = c; end
            if (b8) bs++;
        end
        if (!zr) exp_e8 = ev;
        for (int i = 0; i < 8; i++) g[i] = v8[i];
        chk_run(t, 8, dn, at, bs, i8, c8, z8, e8, g,
                it, cv, zr, exp_e8, vx, cy);
    endtask

    function automatic void clr(output longint a [8][8]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) a[i][j] = 0;
    endfunction

    initial begin
        longint a [8][8];
        eig2 = '0;
        eig8 = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) mat2[i][j] = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) mat8[i][j] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset2("init");
        chk("init.u8_busy", b8, 0);
        chk("init.u8_vec7", v8[7], 0);
        rst = 1'b1;
        @(posedge clk);

        clr(a); a[0][0] = 131072; a[1][1] = 131072;
        run2("diag2", a, 12345, 0);
        chk("diag2.lit_iter", ia, 1);
        chk("diag2.lit_vec1", va[1], 65536);
        chk("diag2.lit_eig", ea, 12345);

        clr(a); a[0][0] = 131072; a[1][1] = 65536;
        run2("halve", a, 777, 0);
        chk("halve.lit_iter", ia, 12);
        chk("halve.lit_vec1", va[1], 16);
        chk("halve.lit_capb", ib, 5);

        clr(a);
        run2("zero", a, 999, 0);
        chk("zero.lit_eig", ea, 777);
        chk("zero.lit_flag", za, 1);

        clr(a); a[0][1] = -65536; a[1][0] = 65536;
        run2("rot", a, -4242, 0);
        chk("rot.lit_iterb", ib, 5);
        chk("rot.lit_convb", cb, 0);
        chk("rot.lit_eigb", eb, -4242);

        clr(a); a[0][0] = 98304; a[0][1] = 16384; a[1][0] = 8192;
        a[1][1] = 49152;
        run2("disturb", a, 31337, 1);
        run2("reset", a, 555, 2);
        run2("after_rst", a, 556, 0);

        for (int r = 0; r < 20; r++) begin
            clr(a);
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    a[i][j] = longint'($urandom_range(0, 262144)) - 131072;
            if (r % 7 == 3) a[1][0] = 0;
            run2("rnd2", a, int'($urandom), (r % 5 == 4) ? 1 : 0);
        end

        clr(a);
        for (int i = 0; i < 8; i++) a[i][i] = 65536;
        run8("ident8", a, 8888);
        chk("ident8.lit_iter", i8, 1);
        chk("ident8.lit_vec5", v8[5], 65536);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8; j++)
                    a[i][j] = longint'($urandom_range(0, 32768)) - 16384;
            a[r][r] = 131072;
            run8("rnd8", a, int'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
